// File: rtl/neuron_wb_loader.sv
// Streams weight and bias words into a bank of neurons, one neuron at a time.
// All state updates happen on the falling edge of clock_n.
`timescale 1ns/1ps

module neuron_wb_loader #(
    parameter int WEIGHT_SIZE = 16,
    parameter int NUM_INPUTS  = 3,
    parameter int NUM_NEURONS = 4
) (
    input  logic                          clock_n,
    input  logic                          reset,
    input  logic                          start,
    input  logic signed [WEIGHT_SIZE-1:0] word_in,
    input  logic                          word_valid,
    output logic                          word_ready,
    output logic signed [WEIGHT_SIZE-1:0] weights_out [NUM_INPUTS],
    output logic signed [WEIGHT_SIZE-1:0] bias_out,
    output logic                          wb_en,
    output logic [NUM_NEURONS-1:0]        neuron_sel,
    output logic                          busy,
    output logic                          done
);

    localparam int WCW = $clog2(NUM_INPUTS + 1);
    localparam int NCW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT, FINISH} state_t;

    state_t         state, state_nxt;
    logic [WCW-1:0] word_cnt, word_cnt_nxt;
    logic [NCW-1:0] neuron_cnt, neuron_cnt_nxt;
    logic           xfer;
    logic           last_word;
    logic           last_neuron;

    assign xfer        = word_ready && word_valid;
    assign last_word   = (word_cnt == WCW'(NUM_INPUTS));
    assign last_neuron = (neuron_cnt == NCW'(NUM_NEURONS - 1));
    assign busy        = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(negedge clock_n or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            word_cnt   <= '0;
            neuron_cnt <= '0;
        end else begin
            state      <= state_nxt;
            word_cnt   <= word_cnt_nxt;
            neuron_cnt <= neuron_cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt      = state;
        word_cnt_nxt   = word_cnt;
        neuron_cnt_nxt = neuron_cnt;
        word_ready     = 1'b0;
        wb_en          = 1'b0;
        neuron_sel     = '0;
        done           = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt      = COLLECT;
                    word_cnt_nxt   = '0;
                    neuron_cnt_nxt = '0;
                end
            end
            COLLECT: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    if (last_word) state_nxt    = COMMIT;
                    else           word_cnt_nxt = word_cnt + 1'b1;
                end
            end
            COMMIT: begin
                wb_en      = 1'b1;
                neuron_sel = NUM_NEURONS'(1) << neuron_cnt;
                if (last_neuron) begin
                    state_nxt = FINISH;
                end else begin
                    state_nxt      = COLLECT;
                    neuron_cnt_nxt = neuron_cnt + 1'b1;
                    word_cnt_nxt   = '0;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the weight registers are few and drive the neurons directly, so
    // they are cleared on reset rather than left as uninitialised storage.
    always_ff @(negedge clock_n or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) weights_out[i] <= '0;
            bias_out <= '0;
        end else if (xfer) begin
            if (last_word) begin
                bias_out <= word_in;
            end else begin
                for (int i = 0; i < NUM_INPUTS; i++)
                    if (word_cnt == WCW'(i)) weights_out[i] <= word_in;
            end
        end
    end

endmodule
